cpu_mem_ctrl: RTL and testbench
===============================

CPU_MEM_CTRL -- requirements
Module: cpu_mem_ctrl

Interface
REQ-001 The block SHALL have parameter TX_DEPTH, default 4, the TX FIFO depth in entries (power of 2, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is clocked on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 The block SHALL have port i_mem_addr, input, 16, CPU byte address (bit 0 ignored).
REQ-005 The block SHALL have ports i_mem_rd (input, 1, CPU read strobe) and i_mem_wr (input, 1, CPU write strobe).
REQ-006 The block SHALL have port i_mem_wrdata, input, 16, CPU write data.
REQ-007 The block SHALL have port o_mem_rddata, output, 16, read data returned to the CPU.
REQ-008 The block SHALL have ports o_ram_addr (output, 15, RAM word address = i_mem_addr[15:1]), o_ram_rd (output, 1), o_ram_wr (output, 1) and o_ram_wrdata (output, 16).
REQ-009 The block SHALL have port i_ram_rddata, input, 16, synchronous-RAM read data valid one cycle after o_ram_rd.
REQ-010 The block SHALL have ports i_sw (input, 8, asynchronous switches) and o_led (output, 8, LED register).
REQ-011 The block SHALL have ports o_tx_data (output, 16), o_tx_valid (output, 1) and i_tx_ready (input, 1) forming a valid/ready TX stream.
REQ-012 The block SHALL have port o_irq, output, 1, the timer interrupt flag.

Function
REQ-013 Addresses 0x0000-0x7FFF SHALL be RAM; the RAM strobes SHALL be combinational pass-throughs, gated by i_mem_addr[15]==0.
REQ-014 The MMIO map SHALL be: 0x8000 LED (RW, bits 7:0); 0x8002 SW (RO); 0x8004 TCOUNT (RO); 0x8006 TCMP (RW); 0x8008 TCTRL (bit0 enable RW, bit1 irq flag, write-1-to-clear); 0x800A TXDATA (WO push); 0x800C TXSTAT (RO: bit0 full, bit1 empty, bit2 sticky overflow, bits 8:4 count).
REQ-015 Unmapped MMIO reads SHALL return 0x0000, and unmapped writes SHALL be ignored.
REQ-016 Read latency SHALL be exactly one cycle for all regions; a registered region select SHALL steer o_mem_rddata to either i_ram_rddata or the registered MMIO read value.
REQ-017 On a simultaneous read and write to the same MMIO register, the read SHALL return the pre-write value.
REQ-018 i_sw SHALL pass through a 2-flop synchronizer, and SW reads SHALL return {8'h00, synced value}.
REQ-019 When enabled, TCOUNT SHALL increment once per cycle; when TCOUNT==TCMP, the next value SHALL be 0 and the irq flag SHALL set; with no match, TCOUNT SHALL wrap from 0xFFFF to 0.
REQ-020 When an irq set and a write-1-clear occur in the same cycle, the set SHALL win.
REQ-021 o_irq SHALL equal the irq flag.
REQ-022 A write to TCOUNT's address SHALL be ignored.
REQ-023 A TXDATA write SHALL push i_mem_wrdata when the FIFO is not full.
REQ-024 A TXDATA write while the FIFO is full SHALL be dropped and SHALL set the sticky overflow bit.
REQ-025 The sticky overflow bit SHALL clear only on a write of 1 to TXSTAT bit2.
REQ-026 A pop SHALL occur when o_tx_valid && i_tx_ready, and o_tx_data SHALL be the FIFO head.
REQ-027 A simultaneous push and pop while full SHALL be accepted with count unchanged, and a push to an empty FIFO SHALL raise o_tx_valid the next cycle (no bypass).
REQ-028 o_tx_data SHALL hold its value while o_tx_valid is high and i_tx_ready is low.

Reset
REQ-029 While reset is 0, LED, TCOUNT, TCTRL, the irq flag, the overflow bit, the FIFO pointers/count, the synchronizer flops and the read-select/read-data registers SHALL be 0.
REQ-030 TCMP SHALL reset to 0xFFFF.
REQ-031 Out of reset, o_mem_rddata, o_led, o_tx_valid and o_irq SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and any pending read return.

Structure
REQ-033 The MMIO address constants, the TXSTAT/TCTRL bit positions and the TX_DEPTH default SHALL live in shared package mem_map_pkg.
REQ-034 The TX FIFO SHALL be a sub-module tx_fifo (push/pop, full/empty/count outputs).

Verification
REQ-035 Write 0x1234 to 0x0010, then read 0x0010 -> o_ram_wr=1 with o_ram_addr=0x0008, and o_mem_rddata=0x1234 one cycle after the read.
REQ-036 Write 0x00A5 to 0x8000, then read 0x8000 -> o_led=0xA5 the next cycle and read data 0x00A5; a read of 0x80F0 returns 0x0000.
REQ-037 TCMP=3 with TCTRL=1 -> TCOUNT sequence 0,1,2,3,0, o_irq rises on the cycle TCOUNT returns to 0; a write of 0x0003 to 0x8008 clears o_irq and keeps enable.
REQ-038 TX_DEPTH=4 with i_tx_ready=0, five writes 0x0001-0x0005 -> TXSTAT full=1, overflow=1, count=4; then i_tx_ready=1 -> outputs 0x0001-0x0004 in order, then empty.
REQ-039 FIFO full, push 0x0009 and pop in the same cycle -> count stays 4, and 0x0009 emerges last.
REQ-040 Assert reset mid-stream with 2 entries queued -> o_tx_valid=0 and TXSTAT empty=1 immediately; i_sw=0x3C reads back 0x003C only after two clock edges.

Source files
------------

// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_map_pkg
//  Description : Shared MMIO address map, TCTRL/TXSTAT bit positions, the
//                read-return region select type and the TX FIFO depth default
//                used by cpu_mem_ctrl and its sub-modules.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

  localparam int TX_DEPTH_DEFAULT = 4;

  // MMIO register byte addresses (bit 0 is ignored when decoding)
  localparam logic [15:0] ADDR_LED    = 16'h8000;
  localparam logic [15:0] ADDR_SW     = 16'h8002;
  localparam logic [15:0] ADDR_TCOUNT = 16'h8004;
  localparam logic [15:0] ADDR_TCMP   = 16'h8006;
  localparam logic [15:0] ADDR_TCTRL  = 16'h8008;
  localparam logic [15:0] ADDR_TXDATA = 16'h800A;
  localparam logic [15:0] ADDR_TXSTAT = 16'h800C;

  // TCTRL bit positions
  localparam int TCTRL_EN_BIT  = 0;
  localparam int TCTRL_IRQ_BIT = 1;

  // TXSTAT bit positions
  localparam int TXSTAT_FULL_BIT  = 0;
  localparam int TXSTAT_EMPTY_BIT = 1;
  localparam int TXSTAT_OVF_BIT   = 2;
  localparam int TXSTAT_CNT_LSB   = 4;
  localparam int TXSTAT_CNT_MSB   = 8;

  // Which source drives the CPU read data one cycle after a read
  typedef enum logic {
    RD_SEL_MMIO = 1'b0,
    RD_SEL_RAM  = 1'b1
  } rd_sel_e;

  // Word-address compare: callers pass address bits [15:1] only
  function automatic logic addr_hit(input logic [14:0] word_addr,
                                    input logic [14:0] reg_word_addr);
    return word_addr == reg_word_addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous FIFO for the TX stream. Head is presented on
//                o_data with o_valid; no push-to-output bypass. A push is
//                accepted when not full, or when full with a concurrent pop.
//  Ports       : clk, reset (async active-low)
//                i_push/i_data  - write side
//                i_pop          - read side (ignored when empty)
//                o_data/o_valid - FIFO head
//                o_full/o_empty/o_count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot the push needs
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage carries no reset; the pointers alone define valid contents
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_valid = ~w_empty;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_ctrl
//  Description : CPU memory controller. Lower 32 KiB passes through to a
//                synchronous RAM; upper half is an MMIO block with LED,
//                switch input, compare-match timer with IRQ and a TX FIFO.
//                All reads return data exactly one cycle after the strobe.
//  Ports       : clk, reset (async active-low)
//                i_mem_*  / o_mem_rddata  - CPU bus
//                o_ram_*  / i_ram_rddata  - synchronous RAM
//                i_sw, o_led              - switches / LED register
//                o_tx_data/o_tx_valid/i_tx_ready - TX valid/ready stream
//                o_irq                    - timer interrupt flag
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_ctrl
  import mem_map_pkg::*;
#(
  parameter int TX_DEPTH = TX_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic [15:0] o_mem_rddata,
  output logic [14:0] o_ram_addr,
  output logic        o_ram_rd,
  output logic        o_ram_wr,
  output logic [15:0] o_ram_wrdata,
  input  logic [15:0] i_ram_rddata,
  input  logic [7:0]  i_sw,
  output logic [7:0]  o_led,
  output logic [15:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_irq
);

  localparam int CW    = $clog2(TX_DEPTH) + 1;
  localparam int CNT_W = TXSTAT_CNT_MSB - TXSTAT_CNT_LSB + 1;

  // Registers
  logic [7:0]  led_q,    led_d;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;
  logic [15:0] tcount_q, tcount_d;
  logic [15:0] tcmp_q,   tcmp_d;
  logic        ten_q,    ten_d;
  logic        irq_q,    irq_d;
  logic        ovf_q,    ovf_d;
  rd_sel_e     rd_sel_q, rd_sel_d;
  logic [15:0] rddata_q, rddata_d;

  // Decode
  logic        w_mmio;
  logic        w_rd_mmio;
  logic        w_wr_mmio;
  logic [14:0] w_word;
  logic        w_wr_led, w_wr_tcmp, w_wr_tctrl, w_wr_txdata, w_wr_txstat;
  logic [15:0] w_mmio_rd;

  // FIFO status
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;
  logic          w_pop;
  logic          w_drop;
  logic          w_unused_ok;

  assign w_word    = i_mem_addr[15:1];
  assign w_mmio    = i_mem_addr[15];
  assign w_rd_mmio = i_mem_rd & w_mmio;
  assign w_wr_mmio = i_mem_wr & w_mmio;

  assign w_wr_led    = w_wr_mmio & addr_hit(w_word, ADDR_LED[15:1]);
  assign w_wr_tcmp   = w_wr_mmio & addr_hit(w_word, ADDR_TCMP[15:1]);
  assign w_wr_tctrl  = w_wr_mmio & addr_hit(w_word, ADDR_TCTRL[15:1]);
  assign w_wr_txdata = w_wr_mmio & addr_hit(w_word, ADDR_TXDATA[15:1]);
  assign w_wr_txstat = w_wr_mmio & addr_hit(w_word, ADDR_TXSTAT[15:1]);

  // Byte lane bit is meaningless on a 16-bit word bus
  assign w_unused_ok = &{1'b1, i_mem_addr[0]};

  // RAM pass-through
  assign o_ram_addr   = i_mem_addr[15:1];
  assign o_ram_rd     = i_mem_rd & ~w_mmio;
  assign o_ram_wr     = i_mem_wr & ~w_mmio;
  assign o_ram_wrdata = i_mem_wrdata;

  // TX FIFO
  assign w_pop  = o_tx_valid & i_tx_ready;
  assign w_drop = w_wr_txdata & w_fifo_full & ~w_pop;

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (16)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_txdata),
    .i_data  (i_mem_wrdata),
    .i_pop   (w_pop),
    .o_data  (o_tx_data),
    .o_valid (o_tx_valid),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // MMIO read mux, built from current (pre-write) register values
  always_comb begin
    w_mmio_rd = 16'h0000;
    if (addr_hit(w_word, ADDR_LED[15:1])) begin
      w_mmio_rd = {8'h00, led_q};
    end else if (addr_hit(w_word, ADDR_SW[15:1])) begin
      w_mmio_rd = {8'h00, sw_sync_q};
    end else if (addr_hit(w_word, ADDR_TCOUNT[15:1])) begin
      w_mmio_rd = tcount_q;
    end else if (addr_hit(w_word, ADDR_TCMP[15:1])) begin
      w_mmio_rd = tcmp_q;
    end else if (addr_hit(w_word, ADDR_TCTRL[15:1])) begin
      w_mmio_rd[TCTRL_EN_BIT]  = ten_q;
      w_mmio_rd[TCTRL_IRQ_BIT] = irq_q;
    end else if (addr_hit(w_word, ADDR_TXSTAT[15:1])) begin
      w_mmio_rd[TXSTAT_FULL_BIT]  = w_fifo_full;
      w_mmio_rd[TXSTAT_EMPTY_BIT] = w_fifo_empty;
      w_mmio_rd[TXSTAT_OVF_BIT]   = ovf_q;
      w_mmio_rd[TXSTAT_CNT_MSB:TXSTAT_CNT_LSB] = CNT_W'(w_fifo_count);
    end
  end

  // Next-state logic
  always_comb begin
    led_d    = led_q;
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    ten_d    = ten_q;
    irq_d    = irq_q;
    ovf_d    = ovf_q;
    rd_sel_d = (i_mem_rd & ~w_mmio) ? RD_SEL_RAM : RD_SEL_MMIO;
    rddata_d = w_rd_mmio ? w_mmio_rd : 16'h0000;

    if (w_wr_led)   led_d  = i_mem_wrdata[7:0];
    if (w_wr_tcmp)  tcmp_d = i_mem_wrdata;
    if (w_wr_tctrl) begin
      ten_d = i_mem_wrdata[TCTRL_EN_BIT];
      if (i_mem_wrdata[TCTRL_IRQ_BIT]) irq_d = 1'b0;
    end

    // Timer: assigned after the clear so a same-cycle match wins
    if (ten_q) begin
      if (tcount_q == tcmp_q) begin
        tcount_d = 16'h0000;
        irq_d    = 1'b1;
      end else begin
        tcount_d = tcount_q + 16'd1;
      end
    end

    if (w_wr_txstat & i_mem_wrdata[TXSTAT_OVF_BIT]) ovf_d = 1'b0;
    if (w_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= 8'h00;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
      tcount_q  <= 16'h0000;
      tcmp_q    <= 16'hFFFF;
      ten_q     <= 1'b0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_sel_q  <= RD_SEL_MMIO;
      rddata_q  <= 16'h0000;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= i_sw;
      sw_sync_q <= sw_meta_q;
      tcount_q  <= tcount_d;
      tcmp_q    <= tcmp_d;
      ten_q     <= ten_d;
      irq_q     <= irq_d;
      ovf_q     <= ovf_d;
      rd_sel_q  <= rd_sel_d;
      rddata_q  <= rddata_d;
    end
  end

  // Idle select is MMIO with zero data, so the bus reads 0 out of reset
  assign o_mem_rddata = (rd_sel_q == RD_SEL_RAM) ? i_ram_rddata : rddata_q;
  assign o_led        = led_q;
  assign o_irq        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_mem_ctrl
//  Description : Directed self-checking bench for cpu_mem_ctrl (TX_DEPTH=4)
//                with a behavioural synchronous RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] i_mem_addr = '0;
  logic        i_mem_rd = 1'b0;
  logic        i_mem_wr = 1'b0;
  logic [15:0] i_mem_wrdata = '0;
  logic [15:0] o_mem_rddata;
  logic [14:0] o_ram_addr;
  logic        o_ram_rd;
  logic        o_ram_wr;
  logic [15:0] o_ram_wrdata;
  logic [15:0] i_ram_rddata = '0;
  logic [7:0]  i_sw = '0;
  logic [7:0]  o_led;
  logic [15:0] o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic        o_irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ram_model [32768];
  logic [15:0] exp_cnt [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
  logic        exp_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] exp_tx  [4] = '{16'h0012, 16'h0013, 16'h0014, 16'h0009};

  cpu_mem_ctrl #(.TX_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_mem_addr   (i_mem_addr),
    .i_mem_rd     (i_mem_rd),
    .i_mem_wr     (i_mem_wr),
    .i_mem_wrdata (i_mem_wrdata),
    .o_mem_rddata (o_mem_rddata),
    .o_ram_addr   (o_ram_addr),
    .o_ram_rd     (o_ram_rd),
    .o_ram_wr     (o_ram_wr),
    .o_ram_wrdata (o_ram_wrdata),
    .i_ram_rddata (i_ram_rddata),
    .i_sw         (i_sw),
    .o_led        (o_led),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_irq        (o_irq)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (o_ram_wr) ram_model[o_ram_addr] <= o_ram_wrdata;
    if (o_ram_rd) i_ram_rddata <= ram_model[o_ram_addr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
    i_mem_addr   = a;
    i_mem_wrdata = d;
    i_mem_wr     = 1'b1;
    tick();
    i_mem_wr     = 1'b0;
  endtask

  task automatic mem_read(input logic [15:0] a, output logic [15:0] d);
    i_mem_addr = a;
    i_mem_rd   = 1'b1;
    tick();
    i_mem_rd   = 1'b0;
    d          = o_mem_rddata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;

    // Reset state
    repeat (3) tick();
    check("rst_rddata", o_mem_rddata, 16'h0000);
    check("rst_led",    {8'h00, o_led}, 16'h0000);
    check("rst_txvalid", {15'b0, o_tx_valid}, 16'h0000);
    check("rst_irq",    {15'b0, o_irq}, 16'h0000);
    reset = 1'b1;
    tick();

    // RAM write then read
    i_mem_addr = 16'h0010; i_mem_wrdata = 16'h1234; i_mem_wr = 1'b1;
    #1;
    check("ram_wr_strobe", {15'b0, o_ram_wr}, 16'h0001);
    check("ram_addr",      {1'b0, o_ram_addr}, 16'h0008);
    check("ram_rd_idle",   {15'b0, o_ram_rd}, 16'h0000);
    check("ram_wrdata",    o_ram_wrdata, 16'h1234);
    tick();
    i_mem_wr = 1'b0;
    mem_read(16'h0010, d);
    check("ram_read", d, 16'h1234);

    // LED register
    i_mem_addr = 16'h8000; i_mem_wrdata = 16'h00A5; i_mem_wr = 1'b1;
    #1;
    check("mmio_no_ram_wr", {15'b0, o_ram_wr}, 16'h0000);
    tick();
    i_mem_wr = 1'b0;
    check("led_out", {8'h00, o_led}, 16'h00A5);
    mem_read(16'h8000, d);
    check("led_read", d, 16'h00A5);
    mem_read(16'h8001, d);
    check("led_read_odd", d, 16'h00A5);
    mem_read(16'h80F0, d);
    check("unmapped_read", d, 16'h0000);

    // Simultaneous read and write returns the old value
    i_mem_addr = 16'h8000; i_mem_wrdata = 16'h005A; i_mem_rd = 1'b1; i_mem_wr = 1'b1;
    tick();
    i_mem_rd = 1'b0; i_mem_wr = 1'b0;
    check("rw_same_old", o_mem_rddata, 16'h00A5);
    check("rw_same_led", {8'h00, o_led}, 16'h005A);

    // Timer: TCMP=3, enable, then watch TCOUNT each cycle
    mem_write(16'h8006, 16'h0003);
    mem_read(16'h8006, d);
    check("tcmp_read", d, 16'h0003);
    mem_write(16'h8008, 16'h0001);
    i_mem_addr = 16'h8004; i_mem_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("tcount_%0d", i), o_mem_rddata, exp_cnt[i]);
      check($sformatf("irq_%0d", i), {15'b0, o_irq}, {15'b0, exp_irq[i]});
    end
    i_mem_rd = 1'b0;
    mem_write(16'h8008, 16'h0003);
    check("irq_w1c", {15'b0, o_irq}, 16'h0000);
    mem_read(16'h8008, d);
    check("tctrl_en_kept", d, 16'h0001);
    mem_write(16'h8008, 16'h0000);
    check("irq_set_on_match", {15'b0, o_irq}, 16'h0001);
    mem_write(16'h8008, 16'h0002);
    check("irq_clear_disabled", {15'b0, o_irq}, 16'h0000);
    mem_write(16'h8004, 16'h1234);
    mem_read(16'h8004, d);
    check("tcount_ro", d, 16'h0000);

    // TX FIFO fill with overflow
    i_tx_ready = 1'b0;
    i_mem_addr = 16'h800A; i_mem_wrdata = 16'h0001; i_mem_wr = 1'b1;
    #1;
    check("tx_no_bypass", {15'b0, o_tx_valid}, 16'h0000);
    tick();
    i_mem_wr = 1'b0;
    check("tx_valid_next", {15'b0, o_tx_valid}, 16'h0001);
    for (int v = 2; v <= 5; v++) mem_write(16'h800A, 16'(v));
    check("tx_hold", o_tx_data, 16'h0001);
    mem_read(16'h800C, d);
    check("txstat_full_ovf", d, 16'h0045);
    i_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx_valid_%0d", i), {15'b0, o_tx_valid}, 16'h0001);
      check($sformatf("tx_data_%0d", i), o_tx_data, 16'(i + 1));
      tick();
    end
    i_tx_ready = 1'b0;
    check("tx_drained", {15'b0, o_tx_valid}, 16'h0000);
    mem_read(16'h800C, d);
    check("txstat_empty_ovf", d, 16'h0006);
    mem_write(16'h800C, 16'h0004);
    mem_read(16'h800C, d);
    check("txstat_ovf_clr", d, 16'h0002);

    // Push and pop together while full
    for (int v = 16'h11; v <= 16'h14; v++) mem_write(16'h800A, 16'(v));
    i_mem_addr = 16'h800A; i_mem_wrdata = 16'h0009; i_mem_wr = 1'b1; i_tx_ready = 1'b1;
    tick();
    i_mem_wr = 1'b0; i_tx_ready = 1'b0;
    mem_read(16'h800C, d);
    check("txstat_full_pushpop", d, 16'h0041);
    i_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx2_data_%0d", i), o_tx_data, exp_tx[i]);
      tick();
    end
    i_tx_ready = 1'b0;
    check("tx2_drained", {15'b0, o_tx_valid}, 16'h0000);

    // Reset mid-stream
    mem_write(16'h800A, 16'h0021);
    mem_write(16'h800A, 16'h0022);
    check("pre_rst_valid", {15'b0, o_tx_valid}, 16'h0001);
    mem_read(16'h8000, d);
    check("pre_rst_read", d, 16'h005A);
    reset = 1'b0;
    #1;
    check("midrst_txvalid", {15'b0, o_tx_valid}, 16'h0000);
    check("midrst_rddata", o_mem_rddata, 16'h0000);
    check("midrst_led", {8'h00, o_led}, 16'h0000);
    tick();
    tick();
    reset = 1'b1;
    mem_read(16'h800C, d);
    check("post_rst_txstat", d, 16'h0002);
    mem_read(16'h8006, d);
    check("post_rst_tcmp", d, 16'hFFFF);

    // Switch synchronizer
    i_sw = 8'h3C;
    mem_read(16'h8002, d);
    check("sw_not_yet", d, 16'h0000);
    tick();
    mem_read(16'h8002, d);
    check("sw_synced", d, 16'h003C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
